sevenseg_scan: RTL and testbench
================================

# sevenseg_scan

Eight-digit multiplexed seven-segment driver that consumes the two slow clocks produced by the board clock generator: `clk_5KHz` paces digit scanning and `clk_4sec` flips between two 32-bit display pages. Both slow clocks are treated as asynchronous data inputs. They are synchronised and edge-detected inside the `clk100MHz` domain, so the whole block runs on one clock. It drives the board's common-anode digit enables and cathode segments directly.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth for `clk_5KHz` and `clk_4sec`; minimum 2.

Ports:
- `clk100MHz`  in  1: system clock, 100 MHz; the only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `clk_5KHz`  in  1: scan pacing input; each rising edge advances the digit.
- `clk_4sec`  in  1: page pacing input; each rising edge toggles the page.
- `page0_data`  in  32: eight hex nibbles for page 0; nibble k is shown on digit k.
- `page1_data`  in  32: eight hex nibbles for page 1.
- `dp_mask`  in  8: decimal point enables, bit k for digit k, active-high.
- `an`  out  8: digit enables, active-low, one-hot-low when lit.
- `seg`  out  7: cathodes, active-low; `seg[0]` is segment a through `seg[6]` is segment g.
- `dp`  out  1: decimal point cathode, active-low.
- `page`  out  1: currently displayed page.

## Operation
- **Synchronisers.** Each slow input passes through a `SYNC_STAGES` flop chain, then a one-flop edge register. A rise pulse is `sync & ~prev`. Synchroniser and edge registers reset to 0.
- **Page register.** Toggles on each `clk_4sec` rise pulse.
- **Digit counter.** 3 bits. Increments on each `clk_5KHz` rise pulse and wraps 7 to 0.
- **Frame snapshot.** When the counter wraps 7 to 0, and once on the first cycle after reset release, the block latches `{page ? page1_data : page0_data}` and `dp_mask` into 32-bit and 8-bit shadow registers. The digits of one frame never mix two pages or two data values (no tearing).
- **Decode.** The nibble for the current digit goes through `hex7seg`, a combinational decoder for full hex 0-F with the standard a-g patterns, active-low.
- **Output registers.**
  - `an = ~(8'b1 << digit)`
  - `seg` = decoded pattern
  - `dp = ~dp_shadow[digit]`
  - All three are registered.
- **Simultaneous page and scan pulses.** If both pulses occur in the same cycle and the scan pulse causes a wrap, the snapshot uses the new page value.
- **Page pulse mid-frame.** Affects only `page`; the displayed data changes at the next wrap.
- **Reset assertion at any time.** Immediately forces all outputs to their reset values.

## Timing
- **Reset values:** `an = 8'hFF` (all dark), `seg = 7'h7F`, `dp = 1`, `page = 0`, digit = 0, shadows = 0.
- **Scan latency.** From a `clk_5KHz` rising edge at the input to the new `an`/`seg`/`dp` value: `SYNC_STAGES + 2` clock cycles (4 at default):
  - `SYNC_STAGES` cycles of synchronisation,
  - 1 cycle to update the counter,
  - 1 cycle for the output register.
- **Page latency.** `page` updates `SYNC_STAGES + 1` cycles after a `clk_4sec` rising edge.
- **First scan after reset.** The first output update after reset release occurs 2 cycles after release and shows digit 0 of the snapshot.
- **Input high at reset release.** A slow input that is already high at release produces exactly one rise pulse, `SYNC_STAGES + 1` cycles after release.
- **Nominal rates.** With `clk_5KHz` at 5 kHz: 5 kHz per digit, 625 Hz per frame. With `clk_4sec` at 0.25 Hz: the page changes every 4 s.
- **Input pulse width.** Inputs held high or low for fewer than `SYNC_STAGES + 1` cycles are not guaranteed to be detected.

## Configuration
- **`SEVENSEG_BLANK_LEADING_ZERO_EN` defined:**
  - At snapshot time the block computes the index of the most significant non-zero nibble of the data shadow, and holds it in a 3-bit register.
  - Digits above that index are dark during their scan slot: `an` stays `8'hFF`, and `seg` and `dp` are forced to 1.
  - Digit 0 is always lit, so a value of 0 shows a single "0".
- **`SEVENSEG_BLANK_LEADING_ZERO_EN` undefined:** all eight digits are always lit and leading zeros are shown.

## Structure
- **Shared package `sevenseg_pkg`:**
  - the 16 active-low segment pattern constants (`SEG_0` … `SEG_F`),
  - `SEG_BLANK = 7'h7F`,
  - `NUM_DIGITS = 8`.
- **Sub-module `hex7seg`:** the combinational nibble-to-pattern decoder, reusable by other display blocks. It sits under `sevenseg_scan`.
- The synchroniser plus edge detector is a local generate loop, not a separate module.

## Test plan
- **Reset.** Hold `rst_n = 0` with the inputs toggling → `an = FF`, `seg = 7F`, `dp = 1`, `page = 0` throughout. After release, the first digit-0 frame appears 2 cycles later.
- **Scan sequence.** `page0_data = 32'h76543210`, drive 8 `clk_5KHz` rises → `an` steps FE, FD, … 7F.
  - `seg` shows 0 = `40`, 1 = `79`, … 7 = `78`.
  - Each update lands 4 cycles after its edge.
- **Tearing check.** Change `page0_data` to `32'hFFFFFFFF` while digit = 3 → digits 4-7 still show 4-7. The next frame shows all F (`seg = 0E`).
- **Page flip.** `page1_data = 32'hABCDEF01`, pulse `clk_4sec` mid-frame → `page = 1` after 3 cycles. Page 1 data is shown from the next digit-0 slot. The simultaneous page and wrap pulse case selects page 1 at that wrap.
- **Decimal point.** `dp_mask = 8'h05` → `dp = 0` only in the digit 0 and digit 2 slots.
- **Blanking (macro defined).** `page0_data = 32'h00000120` → digits 3-7 keep `an = FF`; digits 0-2 show 0, 2, 1. `page0_data = 0` → only digit 0 lit, showing "0". With the macro undefined → all 8 digits lit.

Source files
------------

// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sevenseg_pkg
//  Description : Shared constants for seven-segment display blocks: active-low
//                a-g patterns (seg[0] = a ... seg[6] = g), the blank pattern,
//                the digit count and a leading-digit helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sevenseg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index of the most significant non-zero nibble; 0 when the value is zero.
  function automatic logic [2:0] top_nonzero_digit(input logic [31:0] value);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (value[k*4 +: 4] != 4'h0) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex7seg.sv
`default_nettype none
// ============================================================================
//  Module      : hex7seg
//  Description : Combinational hex nibble (0-F) to active-low a-g pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex7seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  // Full hex lookup; every nibble value has an explicit pattern.
  always_comb begin
    segments = SEG_BLANK;
    case (nibble)
      4'h0: segments = SEG_0;
      4'h1: segments = SEG_1;
      4'h2: segments = SEG_2;
      4'h3: segments = SEG_3;
      4'h4: segments = SEG_4;
      4'h5: segments = SEG_5;
      4'h6: segments = SEG_6;
      4'h7: segments = SEG_7;
      4'h8: segments = SEG_8;
      4'h9: segments = SEG_9;
      4'hA: segments = SEG_A;
      4'hB: segments = SEG_B;
      4'hC: segments = SEG_C;
      4'hD: segments = SEG_D;
      4'hE: segments = SEG_E;
      4'hF: segments = SEG_F;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sevenseg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : sevenseg_scan
//  Description : Eight-digit multiplexed seven-segment driver. clk_5KHz and
//                clk_4sec are sampled as asynchronous data, synchronised and
//                edge-detected in the clk100MHz domain. Data is snapshotted
//                once per frame so a frame never mixes two values.
//                Optional macro SEVENSEG_BLANK_LEADING_ZERO_EN darkens digits
//                above the most significant non-zero nibble.
//  Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk100MHz,
  input  logic        rst_n,
  input  logic        clk_5KHz,
  input  logic        clk_4sec,
  input  logic [31:0] page0_data,
  input  logic [31:0] page1_data,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        page
);

  // Bit 0 = scan pacing, bit 1 = page pacing.
  logic [1:0] slow_in;
  logic [1:0] rise;

  assign slow_in = {clk_4sec, clk_5KHz};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain;
      logic                   prev;

      // Synchroniser chain followed by a single edge-history flop.
      always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
          chain <= '0;
          prev  <= 1'b0;
        end else begin
          chain <= {chain[SYNC_STAGES-2:0], slow_in[i]};
          prev  <= chain[SYNC_STAGES-1];
        end
      end

      assign rise[i] = chain[SYNC_STAGES-1] & ~prev;
    end
  endgenerate

  logic        scan_rise;
  logic        page_rise;
  logic        page_next;
  logic        wrap;
  logic        snap;
  logic        snap_pending;
  logic [2:0]  digit;
  logic [31:0] data_shadow;
  logic [7:0]  dp_shadow;
  logic [31:0] snap_data;
  logic [3:0]  nibble;
  logic [6:0]  decoded;
  logic        lit;

  assign scan_rise = rise[0];
  assign page_rise = rise[1];
  // The snapshot at a wrap must see a page flip arriving in the same cycle.
  assign page_next = page ^ page_rise;
  assign wrap      = scan_rise && (digit == 3'd7);
  assign snap      = wrap || snap_pending;
  assign snap_data = page_next ? page1_data : page0_data;

  // Page toggle, digit counter and once-per-frame data snapshot.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      page         <= 1'b0;
      digit        <= 3'd0;
      data_shadow  <= '0;
      dp_shadow    <= '0;
      snap_pending <= 1'b1;
    end else begin
      page         <= page_next;
      snap_pending <= 1'b0;
      if (scan_rise) digit <= digit + 3'd1;
      if (snap) begin
        data_shadow <= snap_data;
        dp_shadow   <= dp_mask;
      end
    end
  end

`ifdef SEVENSEG_BLANK_LEADING_ZERO_EN
  logic [2:0] lead_idx;

  // Highest digit worth lighting, captured alongside the data snapshot.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      lead_idx <= 3'd0;
    end else if (snap) begin
      lead_idx <= top_nonzero_digit(snap_data);
    end
  end

  assign lit = (digit <= lead_idx);
`else
  assign lit = 1'b1;
`endif

  assign nibble = data_shadow[{digit, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nibble   (nibble),
    .segments (decoded)
  );

  // Registered digit drive; held dark until the first snapshot has landed.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 8'hFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (!snap_pending) begin
      if (lit) begin
        an  <= ~(8'b1 << digit);
        seg <= decoded;
        dp  <= ~dp_shadow[digit];
      end else begin
        an  <= 8'hFF;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sevenseg_scan
//  Description : Directed self-checking bench for sevenseg_scan with a
//                reference model and an expected-output queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sevenseg_scan;

  logic        clk100MHz = 1'b0;
  logic        rst_n     = 1'b0;
  logic        clk_5KHz  = 1'b0;
  logic        clk_4sec  = 1'b0;
  logic [31:0] page0_data = '0;
  logic [31:0] page1_data = '0;
  logic [7:0]  dp_mask    = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        page;

  sevenseg_scan #(.SYNC_STAGES(2)) dut (
    .clk100MHz  (clk100MHz),
    .rst_n      (rst_n),
    .clk_5KHz   (clk_5KHz),
    .clk_4sec   (clk_4sec),
    .page0_data (page0_data),
    .page1_data (page1_data),
    .dp_mask    (dp_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .page       (page)
  );

  always #5 clk100MHz = ~clk100MHz;

`ifdef SEVENSEG_BLANK_LEADING_ZERO_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  localparam logic [15:0] RESET_OUT = {8'hFF, 7'h7F, 1'b1};

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [7:0] an_tab [8]   = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] sb_q[$];
  logic [15:0] shown;
  int          m_digit;
  logic [31:0] m_shadow;
  logic [7:0]  m_dpsh;
  logic        m_page;
  int          m_lead;

  task automatic tick(input int n);
    repeat (n) @(posedge clk100MHz);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_snapshot();
    bit found;
    m_shadow = m_page ? page1_data : page0_data;
    m_dpsh   = dp_mask;
    m_lead   = 0;
    found    = 1'b0;
    for (int k = 7; k >= 1; k--) begin
      if (!found && m_shadow[k*4 +: 4] != 4'h0) begin
        m_lead = k;
        found  = 1'b1;
      end
    end
  endtask

  function automatic logic [15:0] model_out();
    if (BLANK && m_digit > m_lead) return RESET_OUT;
    return {an_tab[m_digit], seg_tab[m_shadow[m_digit*4 +: 4]], ~m_dpsh[m_digit]};
  endfunction

  // Raise the selected slow inputs, predict, and check page and digit latency.
  task automatic pulse(input bit scan, input bit pg, input string tag);
    logic [15:0] prev_out;
    logic        prev_page;
    logic [15:0] exp;
    prev_out  = shown;
    prev_page = m_page;
    if (pg) m_page = ~m_page;
    if (scan) begin
      m_digit = (m_digit + 1) % 8;
      if (m_digit == 0) model_snapshot();
    end
    shown = model_out();
    sb_q.push_back(shown);
    clk_5KHz = scan;
    clk_4sec = pg;
    tick(2);
    check({tag, " page_before"}, {15'd0, page}, {15'd0, prev_page});
    tick(1);
    check({tag, " page_after"}, {15'd0, page}, {15'd0, m_page});
    check({tag, " out_before"}, {an, seg, dp}, prev_out);
    tick(1);
    exp = sb_q.pop_front();
    check({tag, " out_after"}, {an, seg, dp}, exp);
    clk_5KHz = 1'b0;
    clk_4sec = 1'b0;
    tick(4);
  endtask

  task automatic scan_n(input int n, input string tag);
    for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, tag);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held while the slow inputs toggle.
    page0_data = 32'h76543210;
    dp_mask    = 8'h05;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      clk_5KHz = ~clk_5KHz;
      tick(1);
      clk_4sec = ~clk_4sec;
      check("reset_out", {an, seg, dp}, RESET_OUT);
      check("reset_page", {15'd0, page}, 16'd0);
    end
    clk_5KHz = 1'b0;
    clk_4sec = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("release_plus1", {an, seg, dp}, RESET_OUT);
    m_page  = 1'b0;
    m_digit = 0;
    model_snapshot();
    shown = model_out();
    sb_q.push_back(shown);
    tick(1);
    check("release_plus2", {an, seg, dp}, sb_q.pop_front());

    // Scan sequence with a data change mid-frame.
    scan_n(3, "scan");
    page0_data = 32'hFFFFFFFF;
    scan_n(4, "tear");
    pulse(1'b1, 1'b0, "wrap_all_f");

    // Page flip mid-frame takes effect at the next wrap.
    page1_data = 32'hABCDEF01;
    scan_n(1, "scan_p");
    pulse(1'b0, 1'b1, "page_mid");
    scan_n(6, "scan_p");
    pulse(1'b1, 1'b0, "wrap_page1");

    // Simultaneous page and wrap pulses: snapshot follows the new page.
    page0_data = 32'h13579BDF;
    scan_n(7, "scan_s");
    pulse(1'b1, 1'b1, "sim_to_p0");
    page1_data = 32'h00000120;
    scan_n(7, "scan_s");
    pulse(1'b1, 1'b1, "sim_to_p1");
    scan_n(7, "blank120");

    // All-zero value.
    page1_data = 32'h00000000;
    scan_n(8, "blank0");

    // Reset asserted mid-cycle forces outputs immediately.
    @(posedge clk100MHz);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", {an, seg, dp}, RESET_OUT);
    check("async_reset_page", {15'd0, page}, 16'd0);
    tick(2);
    check("reset_hold_out", {an, seg, dp}, RESET_OUT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
